// File: rtl/batrider_snd_host_if.sv
// batrider_snd_host_if: 68000-side end of the main/sound CPU mailbox.
// Owns the command/parameter latches, strobes the sound block, holds DTACK while the
// Z80 has not cleared WAIT, reads back the reply latches and latches SNDIRQ for the 68k.
module batrider_snd_host_if #(
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned ARM_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC = 9600
) (
    input  logic       i_clk96,
    input  logic       i_reset96_n,
    input  logic       i_cpu_cs,
    input  logic       i_cpu_rnw,
    input  logic [2:0] i_cpu_a,
    input  logic [7:0] i_cpu_din,
    output logic [7:0] o_cpu_dout,
    output logic       o_cpu_dtack_n,
    output logic       o_snd_cs,
    input  logic       i_snd_wait,
    input  logic       i_snd_irq,
    output logic [7:0] o_soundlatch,
    output logic [7:0] o_soundlatch2,
    input  logic [7:0] i_soundlatch3,
    input  logic [7:0] i_soundlatch4,
    output logic       o_irq_n,
    output logic       o_timeout
);

    localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYC - 1);
    localparam logic [15:0] ARM_LAST     = 16'(ARM_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StStrobe, StArm, StHold} state_t;

    state_t      r_state, w_state_d;
    logic [15:0] r_cnt, w_cnt_d;
    logic        r_cs_q, r_pend, r_dtack_n;
    logic [7:0]  r_dout, r_latch, r_latch2;
    logic        r_irq_s1, r_irq_s2, r_irq_s3, r_irq_pend, r_timeout;

    logic        w_cs_rise, w_busy, w_latch_wr, w_exec, w_wr, w_start;
    logic        w_irq_rise, w_irq_clr, w_to_set, w_to_clr;
    logic [7:0]  w_rdata;

    assign w_cs_rise  = i_cpu_cs & ~r_cs_q;
    assign w_busy     = (r_state != StIdle);
    assign w_latch_wr = ~i_cpu_rnw & ((i_cpu_a == 3'd0) | (i_cpu_a == 3'd1));
    // A pending access runs unless it would overwrite a latch mid-handshake.
    assign w_exec     = r_pend & i_cpu_cs & ~(w_latch_wr & w_busy);
    assign w_wr       = w_exec & ~i_cpu_rnw;
    assign w_start    = w_wr & (i_cpu_a == 3'd1);
    assign w_irq_rise = r_irq_s2 & ~r_irq_s3;
    assign w_irq_clr  = (w_wr & (i_cpu_a == 3'd5) & i_cpu_din[0])
                      | (w_exec & i_cpu_rnw & (i_cpu_a == 3'd2));
    assign w_to_clr   = w_wr & (i_cpu_a == 3'd5) & i_cpu_din[1];

    // Read data mux for the register map.
    always_comb begin
        w_rdata = 8'hFF;
        case (i_cpu_a)
            3'd2:    w_rdata = i_soundlatch3;
            3'd3:    w_rdata = i_soundlatch4;
            3'd4:    w_rdata = {6'b0, r_timeout, w_busy};
            default: w_rdata = 8'hFF;
        endcase
    end

    // Access tracking: CS edge detect, pending access, DTACK and read data.
    always_ff @(posedge i_clk96 or negedge i_reset96_n) begin
        if (!i_reset96_n) begin
            r_cs_q    <= 1'b0;
            r_pend    <= 1'b0;
            r_dtack_n <= 1'b1;
            r_dout    <= 8'hFF;
        end else begin
            r_cs_q <= i_cpu_cs;
            if (!i_cpu_cs)      r_pend <= 1'b0;
            else if (w_cs_rise) r_pend <= 1'b1;
            else if (w_exec)    r_pend <= 1'b0;
            if (!i_cpu_cs)      r_dtack_n <= 1'b1;
            else if (w_exec)    r_dtack_n <= 1'b0;
            if (w_exec & i_cpu_rnw) r_dout <= w_rdata;
        end
    end

    // Command and parameter latches towards the Z80.
    always_ff @(posedge i_clk96 or negedge i_reset96_n) begin
        if (!i_reset96_n) begin
            r_latch  <= 8'h00;
            r_latch2 <= 8'h00;
        end else begin
            if (w_wr & (i_cpu_a == 3'd0)) r_latch <= i_cpu_din;
            if (w_start)                  r_latch2 <= i_cpu_din;
        end
    end

    // Handshake state and per-state cycle counter.
    always_ff @(posedge i_clk96 or negedge i_reset96_n) begin
        if (!i_reset96_n) begin
            r_state <= StIdle;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Handshake next state; the counter restarts on every state entry.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 16'd1;
        w_to_set  = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_d = 16'd0;
                if (w_start) w_state_d = StStrobe;
            end
            StStrobe: begin
                if (r_cnt == STROBE_LAST) begin
                    w_state_d = StArm;
                    w_cnt_d   = 16'd0;
                end
            end
            StArm: begin
                if (i_snd_wait) begin
                    w_state_d = StHold;
                    w_cnt_d   = 16'd0;
                end else if (r_cnt == ARM_LAST) begin
                    // Z80 already cleared WAIT before we saw it: not an error.
                    w_state_d = StIdle;
                    w_cnt_d   = 16'd0;
                end
            end
            StHold: begin
                if (!i_snd_wait) begin
                    w_state_d = StIdle;
                    w_cnt_d   = 16'd0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_d = StIdle;
                    w_cnt_d   = 16'd0;
                    w_to_set  = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = 16'd0;
            end
        endcase
    end

    // SNDIRQ synchroniser, pending interrupt and sticky timeout; set beats clear.
    always_ff @(posedge i_clk96 or negedge i_reset96_n) begin
        if (!i_reset96_n) begin
            r_irq_s1   <= 1'b0;
            r_irq_s2   <= 1'b0;
            r_irq_s3   <= 1'b0;
            r_irq_pend <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_irq_s1 <= i_snd_irq;
            r_irq_s2 <= r_irq_s1;
            r_irq_s3 <= r_irq_s2;
            if (w_irq_rise)     r_irq_pend <= 1'b1;
            else if (w_irq_clr) r_irq_pend <= 1'b0;
            if (w_to_set)       r_timeout <= 1'b1;
            else if (w_to_clr)  r_timeout <= 1'b0;
        end
    end

    assign o_cpu_dout    = r_dout;
    assign o_cpu_dtack_n = r_dtack_n;
    assign o_snd_cs      = (r_state == StStrobe);
    assign o_soundlatch  = r_latch;
    assign o_soundlatch2 = r_latch2;
    assign o_irq_n       = ~r_irq_pend;
    assign o_timeout     = r_timeout;

endmodule
